vga_sync_monitor: RTL and testbench

- Receive-side counterpart to the PONG VGA output path: consumes the hsync/vsync/rgb stream the top drives and reconstructs pixel coordinates and pixel data.
- Checks the stream against the expected 640x480@60 timing.
- Reports lock state and timing errors.
- Used in simulation benches and as an on-chip loopback checker for the PONG display path.

---
 rtl/vga_sync_monitor.sv | 223 ++++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side checker for a VGA hsync/vsync/rgb stream.
// Rebuilds pixel coordinates, measures line/frame timing and tracks lock.
module vga_sync_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic        px_valid,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic [11:0] px_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines
);
    localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
    localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
    localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
    localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
    localparam logic [10:0] H_ACT_LO  = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_HI  = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [10:0] V_ACT_LO  = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_ACT_HI  = 11'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        if (v == 11'h7FF) begin
            return v;
        end else begin
            return v + 11'd1;
        end
    endfunction

    state_t      state_r, state_next_s;
    logic [10:0] hcnt_r, vcnt_r, vs_lines_r;
    logic        hs_prev_r, line_vs_r, hs_wait_r, frame_err_r;
    logic [3:0]  good_r, good_next_s, good_inc_s;
    logic        frame_err_next_s, err_s;

    logic        hs_edge_s, fs_s, in_region_s;
    logic [10:0] h_inc_s, v_inc_s, h_pos_s, v_pos_s, x_off_s, y_off_s;
    logic        line_err_s, hw_err_s, fl_err_s, vw_err_s, any_err_s;

    // h_pos/v_pos are the coordinates this sample takes (edge sample is column 0)
    assign hs_edge_s   = hs_prev_r & ~hsync;
    assign fs_s        = hs_edge_s & ~vsync & line_vs_r;
    assign h_inc_s     = sat_inc(hcnt_r);
    assign v_inc_s     = sat_inc(vcnt_r);
    assign h_pos_s     = hs_edge_s ? 11'd0 : h_inc_s;
    assign v_pos_s     = fs_s ? 11'd0 : (hs_edge_s ? v_inc_s : vcnt_r);
    assign x_off_s     = h_pos_s - H_ACT_LO;
    assign y_off_s     = v_pos_s - V_ACT_LO;
    assign in_region_s = (h_pos_s >= H_ACT_LO) && (h_pos_s <= H_ACT_HI) &&
                         (v_pos_s >= V_ACT_LO) && (v_pos_s <= V_ACT_HI);

    assign line_err_s  = hs_edge_s & (h_inc_s != H_TOTAL_C);
    assign hw_err_s    = hs_wait_r & hsync & (h_pos_s != H_SYNC_C);
    assign fl_err_s    = fs_s & (v_inc_s != V_TOTAL_C);
    assign vw_err_s    = fs_s & (vs_lines_r != V_SYNC_C);
    assign any_err_s   = pix_en & (line_err_s | hw_err_s | fl_err_s | vw_err_s);
    assign good_inc_s  = good_r + 4'd1;

    // Lock state machine: next state, clean-frame count and error pulse
    always_comb begin
        state_next_s     = state_r;
        good_next_s      = good_r;
        frame_err_next_s = frame_err_r;
        err_s            = 1'b0;
        case (state_r)
            SEARCH: begin
                if (pix_en && fs_s) begin
                    state_next_s     = TRACK;
                    good_next_s      = 4'd0;
                    frame_err_next_s = 1'b0;
                end else begin
                    state_next_s = SEARCH;
                end
            end
            TRACK: begin
                err_s = any_err_s;
                if (pix_en && fs_s) begin
                    frame_err_next_s = 1'b0;
                    if (any_err_s || frame_err_r) begin
                        good_next_s = 4'd0;
                    end else if (good_inc_s >= LOCK_C) begin
                        good_next_s  = good_inc_s;
                        state_next_s = LOCKED;
                    end else begin
                        good_next_s = good_inc_s;
                    end
                end else if (any_err_s) begin
                    good_next_s      = 4'd0;
                    frame_err_next_s = 1'b1;
                end else begin
                    good_next_s = good_r;
                end
            end
            LOCKED: begin
                err_s = any_err_s;
                if (any_err_s) begin
                    state_next_s     = TRACK;
                    good_next_s      = 4'd0;
                    frame_err_next_s = ~fs_s;
                end else begin
                    state_next_s = LOCKED;
                end
            end
            default: begin
                state_next_s     = SEARCH;
                good_next_s      = 4'd0;
                frame_err_next_s = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= SEARCH;
            good_r      <= 4'd0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            good_r      <= good_next_s;
            frame_err_r <= frame_err_next_s;
        end
    end

    // Line/frame position counters and sync history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_r     <= 11'd0;
            vcnt_r     <= 11'd0;
            vs_lines_r <= 11'd0;
            hs_prev_r  <= 1'b1;
            line_vs_r  <= 1'b1;
            hs_wait_r  <= 1'b0;
        end else if (pix_en) begin
            hs_prev_r <= hsync;
            hcnt_r    <= h_pos_s;
            vcnt_r    <= v_pos_s;
            if (hs_edge_s) begin
                line_vs_r <= vsync;
                hs_wait_r <= 1'b1;
            end else if (hsync) begin
                hs_wait_r <= 1'b0;
            end else begin
                hs_wait_r <= hs_wait_r;
            end
            // the frame-start line itself is the first vsync-low line of the new frame
            if (fs_s) begin
                vs_lines_r <= 11'd1;
            end else if (hs_edge_s && !vsync) begin
                vs_lines_r <= sat_inc(vs_lines_r);
            end else begin
                vs_lines_r <= vs_lines_r;
            end
        end else begin
            hcnt_r <= hcnt_r;
        end
    end

    // Registered outputs; pulses clear on idle clocks, everything else holds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px_valid    <= 1'b0;
            px_x        <= 10'd0;
            px_y        <= 10'd0;
            px_rgb      <= 12'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
            line_len    <= 11'd0;
            frame_lines <= 11'd0;
        end else begin
            frame_start <= pix_en & fs_s;
            err         <= err_s;
            locked      <= (state_next_s == LOCKED);
            if (pix_en) begin
                px_valid <= in_region_s & (state_next_s == LOCKED);
                if (in_region_s) begin
                    px_x   <= x_off_s[9:0];
                    px_y   <= y_off_s[9:0];
                    px_rgb <= rgb;
                end else begin
                    px_x <= px_x;
                end
                if (hs_edge_s) begin
                    line_len <= h_inc_s;
                end else begin
                    line_len <= line_len;
                end
                if (fs_s) begin
                    frame_lines <= v_inc_s;
                end else begin
                    frame_lines <= frame_lines;
                end
            end else begin
                px_valid <= px_valid;
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor: scaled-down raster timing so many frames fit in a short run;
// expectations come from the generator's own line/tick indices and a run-length lock model.
module tb_vga_sync_monitor;
    localparam int HA = 16, HS = 4, HBP = 3, HT = 28;
    localparam int VA = 6, VS = 2, VBP = 2, VT = 12, LF = 2;
    localparam int HX0 = HS + HBP;
    localparam int VY0 = VS + VBP;

    logic        clk = 1'b0;
    logic        reset, pix_en, hsync, vsync;
    logic [11:0] rgb;
    logic        px_valid, frame_start, locked, err;
    logic [9:0]  px_x, px_y;
    logic [11:0] px_rgb;
    logic [10:0] line_len, frame_lines;

    int checks = 0;
    int failures = 0;

    // model: run = consecutive clean complete frames since last error
    bit started, frame_clean;
    int run, prev_len, prev_nlines, prev_vsw;

    vga_sync_monitor #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HBP), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VBP), .V_TOTAL(VT), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
        .frame_start(frame_start), .locked(locked), .err(err),
        .line_len(line_len), .frame_lines(frame_lines)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic hs, input logic vs, input logic [11:0] c);
        int idle;
        idle = $urandom_range(0, 2);
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            pix_en = 1'b0;
            hsync  = 1'($urandom);
            vsync  = 1'($urandom);
            rgb    = 12'($urandom);
            @(posedge clk);
            #1;
            chk("idle_pulses", 64'({err, frame_start}), 64'd0);
        end
        @(negedge clk);
        pix_en = 1'b1;
        hsync  = hs;
        vsync  = vs;
        rgb    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int nlines, input int vs_w, input int bad_line, input int bad_w,
                             input int short_line, input int short_len, input int start_line,
                             input int gap_line, input int reset_line);
        int len, w;
        logic [11:0] c;
        bit viol, fs, in_reg, exp_err, saw;
        logic [63:0] snap;
        for (int l = start_line; l < nlines; l++) begin
            len = (l == short_line) ? short_len : HT;
            w   = (l == bad_line) ? bad_w : HS;
            for (int t = 0; t < len; t++) begin
                if (l == reset_line && t == 10) begin
                    #2 reset = 1'b0;
                    #1;
                    chk("reset_px", 64'({px_valid, px_x, px_y, px_rgb}), 64'd0);
                    chk("reset_ctl", 64'({frame_start, locked, err, line_len, frame_lines}), 64'd0);
                    @(negedge clk);
                    pix_en = 1'b0;
                    repeat (2) @(negedge clk);
                    reset = 1'b1;
                    started = 1'b0;
                    run = 0;
                    frame_clean = 1'b1;
                    return;
                end
                if (l == gap_line && t == 12) begin
                    snap = 64'({px_valid, px_x, px_y, px_rgb, locked, line_len, frame_lines});
                    saw = 1'b0;
                    for (int k = 0; k < 1000; k++) begin
                        @(negedge clk);
                        pix_en = 1'b0;
                        hsync  = 1'($urandom);
                        vsync  = 1'($urandom);
                        rgb    = 12'($urandom);
                        @(posedge clk);
                        #1;
                        saw = saw | err | frame_start;
                    end
                    chk("gap_no_pulse", 64'(saw), 64'd0);
                    chk("gap_hold", 64'({px_valid, px_x, px_y, px_rgb, locked, line_len, frame_lines}), snap);
                end
                c  = (l == VY0 && t == HX0) ? 12'hF00 : 12'($urandom);
                fs = (t == 0) && (l == 0);
                viol = 1'b0;
                if (t == 0 && prev_len != HT) viol = 1'b1;
                if (fs && (prev_nlines != VT || prev_vsw != VS)) viol = 1'b1;
                if (t == w && w != HS) viol = 1'b1;
                send(1'(t >= w), 1'(l >= vs_w), c);
                exp_err = started && viol;
                if (fs) begin
                    if (started) run = (frame_clean && !viol) ? run + 1 : 0;
                    else begin
                        started = 1'b1;
                        run = 0;
                    end
                    frame_clean = 1'b1;
                end else if (started && viol) begin
                    run = 0;
                    frame_clean = 1'b0;
                end
                in_reg = (t >= HX0) && (t < HX0 + HA) && (l >= VY0) && (l < VY0 + VA);
                chk("err", 64'(err), 64'(exp_err));
                chk("frame_start", 64'(frame_start), 64'(fs));
                chk("locked", 64'(locked), 64'(run >= LF));
                chk("px_valid", 64'(px_valid), 64'(in_reg && run >= LF));
                if (started && in_reg) begin
                    chk("px_x", 64'(px_x), 64'(t - HX0));
                    chk("px_y", 64'(px_y), 64'(l - VY0));
                    chk("px_rgb", 64'(px_rgb), 64'(c));
                end
            end
            prev_len = len;
        end
        prev_nlines = nlines;
        prev_vsw = vs_w;
    endtask

    initial begin
        reset = 1'b0;
        pix_en = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        rgb = 12'd0;
        started = 1'b0;
        frame_clean = 1'b1;
        run = 0;
        prev_len = HT;
        prev_nlines = VT;
        prev_vsw = VS;
        repeat (3) @(negedge clk);
        chk("por_px", 64'({px_valid, px_x, px_y, px_rgb}), 64'd0);
        chk("por_ctl", 64'({frame_start, locked, err, line_len, frame_lines}), 64'd0);
        reset = 1'b1;

        // nominal lock after three frame starts
        repeat (3) run_frame(VT, VS, -1, 0, -1, 0, 0, -1, -1);
        chk("nom_locked", 64'(locked), 64'd1);
        chk("nom_line_len", 64'(line_len), 64'(HT));
        chk("nom_frame_lines", 64'(frame_lines), 64'(VT));

        // long pix_en gap mid-line while locked
        run_frame(VT, VS, -1, 0, -1, 0, 0, 5, -1);

        // short hsync pulse while locked, then relock
        run_frame(VT, VS, 3, HS - 1, -1, 0, 0, -1, -1);
        chk("hsw_unlock", 64'(locked), 64'd0);
        repeat (3) run_frame(VT, VS, -1, 0, -1, 0, 0, -1, -1);
        chk("hsw_relock", 64'(locked), 64'd1);

        // short frame while tracking
        run_frame(VT, VS, 2, HS + 1, -1, 0, 0, -1, -1);
        run_frame(VT - 1, VS, -1, 0, -1, 0, 0, -1, -1);
        run_frame(VT, VS, -1, 0, -1, 0, 0, -1, -1);
        chk("fl_frame_lines", 64'(frame_lines), 64'(VT - 1));
        repeat (2) run_frame(VT, VS, -1, 0, -1, 0, 0, -1, -1);
        chk("fl_relock", 64'(locked), 64'd1);

        // short line, then over-wide vsync
        run_frame(VT, VS, -1, 0, VT - 2, HT - 5, 0, -1, -1);
        chk("ll_line_len", 64'(line_len), 64'(HT - 5));
        run_frame(VT, VS + 1, -1, 0, -1, 0, 0, -1, -1);
        repeat (3) run_frame(VT, VS, -1, 0, -1, 0, 0, -1, -1);
        chk("vw_relock", 64'(locked), 64'd1);

        // reset mid-frame, resume with a partial frame
        run_frame(VT, VS, -1, 0, -1, 0, 0, -1, 6);
        run_frame(VT, VS, -1, 0, -1, 0, 7, -1, -1);
        chk("rst_partial_unlocked", 64'(locked), 64'd0);
        repeat (3) run_frame(VT, VS, -1, 0, -1, 0, 0, -1, -1);
        chk("rst_relock", 64'(locked), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
